// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding, ACK/NACK bit levels
// and the default bus address of the emulated ADT7420.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8,
        ST_WAIT_STOP = 4'd9
    } i2c_state_t;

    localparam logic       I2C_ACK          = 1'b0;
    localparam logic       I2C_NACK         = 1'b1;
    localparam logic [6:0] I2C_DEFAULT_ADDR = 7'h4B;
    localparam logic [6:0] I2C_GENERAL_CALL = 7'h00;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the asynchronous SCL/SDA bus levels and derives single-cycle
// edge and START/STOP condition pulses.
//   i_clk, reset         : system clock, synchronous active-high reset
//   scl_i, sda_i         : raw bus levels
//   scl_rise, scl_fall   : one-cycle pulses on synchronized SCL edges
//   sda_s                : synchronized SDA level
//   start_det, stop_det  : one-cycle pulses, SDA fall / rise while SCL high
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Idle bus is high; resetting to 1 keeps spurious edges away at reset release.
    always_ff @(posedge i_clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_sync[SYNC_STAGES-1];
            sda_d    <= sda_sync[SYNC_STAGES-1];
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & sda_d & ~sda_s;
    assign stop_det  = scl_s & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing an 8-bit-addressed register window to local logic.
// Supports single/sequential writes, combined-format reads and an
// auto-incrementing register pointer.
//   i_clk, reset   : system clock, synchronous active-high reset
//   scl_i, sda_i   : asynchronous bus levels
//   sda_oe         : 1 = pull SDA low
//   reg_addr       : register pointer
//   reg_wr_en      : one-cycle write strobe with reg_wr_data
//   reg_rd_en      : one-cycle read request; reg_rd_data valid one cycle later
//   busy           : addressed and transfer in progress
//   start_det      : pulse on START / repeated START
//   stop_det       : pulse on STOP
module i2c_slave_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = I2C_DEFAULT_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       reset,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       start_det,
    output logic       stop_det
);

    logic       scl_rise;
    logic       scl_fall;
    logic       sda_s;
    logic       start_p;
    logic       stop_p;

    i2c_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       rw;
    logic       sub_seen;    // sub-address already received in this transaction
    logic       ack_rose;    // ACK clock has risen while we hold SDA low
    logic       rd_first;    // next SCL fall drives bit 7 of the prefetched byte
    logic       rd_capture;  // reg_rd_data is valid this cycle

    i2c_bus_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk    (i_clk),
        .reset    (reset),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .sda_s    (sda_s),
        .start_det(start_p),
        .stop_det (stop_p)
    );

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            bit_cnt     <= 3'd7;
            shift_reg   <= '0;
            rw          <= 1'b0;
            sub_seen    <= 1'b0;
            ack_rose    <= 1'b0;
            rd_first    <= 1'b0;
            rd_capture  <= 1'b0;
            sda_oe      <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            start_det   <= 1'b0;
            stop_det    <= 1'b0;
        end else begin
            reg_wr_en  <= 1'b0;
            reg_rd_en  <= 1'b0;
            start_det  <= start_p;
            stop_det   <= stop_p;
            rd_capture <= reg_rd_en;
            if (rd_capture) shift_reg <= reg_rd_data;
            // Pointer advances the cycle after the write strobe.
            if (reg_wr_en) reg_addr <= reg_addr + 8'd1;

            // Bus conditions take priority over any bit handling this cycle.
            if (stop_p) begin
                state    <= ST_IDLE;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
                sub_seen <= 1'b0;
                ack_rose <= 1'b0;
                rd_first <= 1'b0;
                bit_cnt  <= 3'd7;
            end else if (start_p) begin
                state    <= ST_ADDR;
                sda_oe   <= 1'b0;
                ack_rose <= 1'b0;
                rd_first <= 1'b0;
                bit_cnt  <= 3'd7;
                if (state == ST_IDLE) sub_seen <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_WAIT_STOP: ;

                    ST_ADDR, ST_SUB, ST_WDATA: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s};
                            if (bit_cnt == 3'd0) begin
                                bit_cnt <= 3'd7;
                                if (state == ST_ADDR) begin
                                    if (shift_reg[6:0] == SLAVE_ADDR &&
                                        shift_reg[6:0] != I2C_GENERAL_CALL) begin
                                        state <= ST_ADDR_ACK;
                                        busy  <= 1'b1;
                                        rw    <= sda_s;
                                    end else begin
                                        state <= ST_WAIT_STOP;
                                        busy  <= 1'b0;
                                    end
                                end else if (state == ST_SUB) begin
                                    reg_addr <= {shift_reg[6:0], sda_s};
                                    sub_seen <= 1'b1;
                                    state    <= ST_SUB_ACK;
                                end else begin
                                    reg_wr_en   <= 1'b1;
                                    reg_wr_data <= {shift_reg[6:0], sda_s};
                                    state       <= ST_WDATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    // SDA held low from the fall after bit 0 to the fall after
                    // the ACK clock. A read leaves early at the ACK rise so the
                    // prefetch lines up; RDATA's first fall then replaces the ACK.
                    ST_ADDR_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                        if (scl_fall && !ack_rose) begin
                            sda_oe <= 1'b1;
                        end else if (scl_rise) begin
                            if (state == ST_ADDR_ACK && rw) begin
                                reg_rd_en <= 1'b1;
                                rd_first  <= 1'b1;
                                state     <= ST_RDATA;
                            end else begin
                                ack_rose <= 1'b1;
                            end
                        end else if (scl_fall) begin
                            sda_oe   <= 1'b0;
                            ack_rose <= 1'b0;
                            bit_cnt  <= 3'd7;
                            if (state == ST_ADDR_ACK && !sub_seen) state <= ST_SUB;
                            else                                  state <= ST_WDATA;
                        end
                    end

                    ST_RDATA: begin
                        if (scl_fall) begin
                            if (rd_first) begin
                                sda_oe   <= ~shift_reg[7];
                                rd_first <= 1'b0;
                                bit_cnt  <= 3'd7;
                            end else if (bit_cnt == 3'd0) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RACK;
                            end else begin
                                sda_oe    <= ~shift_reg[6];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                                bit_cnt   <= bit_cnt - 3'd1;
                            end
                        end
                    end

                    ST_RACK: begin
                        if (scl_rise) begin
                            if (sda_s == I2C_ACK) begin
                                reg_addr  <= reg_addr + 8'd1;
                                reg_rd_en <= 1'b1;
                                rd_first  <= 1'b1;
                                state     <= ST_RDATA;
                            end else begin
                                busy  <= 1'b0;
                                state <= ST_WAIT_STOP;
                            end
                        end
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
